fetch_unit: RTL

Instruction-fetch stage of the 5-stage MIPS pipeline: owns the program counter and the IF/ID pipeline register. It is the consumer of the hazard detection unit's stall and flush outputs. It holds the PC and IF/ID on a load-use or branch-operand stall, and inserts a bubble on a taken branch or jump. It redirects the PC to the target selected by ID-stage control. It also keeps sticky protocol-error and saturating stall/flush performance counters.

---
 rtl/fetch_unit_if.sv | 38 +++
 rtl/fetch_unit.sv | 108 ++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundle of the fetch stage's control, target, memory and
// IF/ID signals.
//   master : hazard/ID control and instruction memory side. It drives the stalls,
//            the flush, PCSrc, the targets and IMem_Instr.
//   slave  : fetch_unit. It drives IMem_Addr, the IF/ID fields, Protocol_Err
//            and the performance counters.
// CNT_W sets the counter width. It must match the CNT_W of the fetch_unit bound to it.
interface fetch_unit_if #(parameter int CNT_W = 16);
  logic             PC_Stall;
  logic             IF_ID_Stall;
  logic             IF_ID_Flush;
  logic [1:0]       PCSrc;
  logic [31:0]      ID_BranchTarget;
  logic [31:0]      ID_JumpTarget;
  logic [31:0]      ID_JRTarget;
  logic [31:0]      IMem_Addr;
  logic [31:0]      IMem_Instr;
  logic [31:0]      IF_ID_Instr;
  logic [31:0]      IF_ID_PCPlus4;
  logic             IF_ID_Valid;
  logic             Protocol_Err;
  logic [CNT_W-1:0] Stall_Count;
  logic [CNT_W-1:0] Flush_Count;

  modport master (
    output PC_Stall, IF_ID_Stall, IF_ID_Flush, PCSrc,
           ID_BranchTarget, ID_JumpTarget, ID_JRTarget, IMem_Instr,
    input  IMem_Addr, IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid,
           Protocol_Err, Stall_Count, Flush_Count
  );

  modport slave (
    input  PC_Stall, IF_ID_Stall, IF_ID_Flush, PCSrc,
           ID_BranchTarget, ID_JumpTarget, ID_JRTarget, IMem_Instr,
    output IMem_Addr, IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid,
           Protocol_Err, Stall_Count, Flush_Count
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the 5-stage MIPS pipeline.
// It owns the PC and the IF/ID pipeline register.
// Ports:
//   CLK   : pipeline clock. All state updates on the rising edge.
//   RESET : synchronous, active-high reset. It dominates every other input.
//   bus   : fetch_unit_if.slave. It carries the stall/flush/PCSrc controls,
//           the redirect targets, the instruction memory address/data, the
//           IF/ID outputs, the sticky Protocol_Err flag and the saturating
//           stall/flush counters.
// Every output is a register. IMem_Addr is the PC register itself, so there
// is no combinational path from any input to any output.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic      CLK,
  input  logic      RESET,
  fetch_unit_if.slave bus
);

  logic [31:0]      pc_reg,        pc_next;
  logic [31:0]      instr_reg,     instr_next;
  logic [31:0]      pcplus4_reg,   pcplus4_next;
  logic             valid_reg,     valid_next;
  logic             err_reg,       err_next;
  logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;
  logic [CNT_W-1:0] flush_cnt_reg, flush_cnt_next;

  logic [31:0] pc_plus4;
  logic [31:0] target;

  assign pc_plus4 = pc_reg + 32'd4;   // wraps modulo 2^32

  always_comb begin
    target = pc_plus4;
    case (bus.PCSrc)
      2'b00:   target = pc_plus4;
      2'b01:   target = bus.ID_BranchTarget;
      2'b10:   target = bus.ID_JumpTarget;
      default: target = bus.ID_JRTarget;
    endcase
  end

  always_comb begin
    pc_next        = pc_reg;
    instr_next     = instr_reg;
    pcplus4_next   = pcplus4_reg;
    valid_next     = valid_reg;
    err_next       = err_reg;
    stall_cnt_next = stall_cnt_reg;
    flush_cnt_next = flush_cnt_reg;

    // PC_Stall ignores PCSrc. A redirect that arrives during a stall is
    // picked up again from ID once the stall releases.
    if (!bus.PC_Stall)
      pc_next = {target[31:2], 2'b00};

    // A flush beats a stall, so a bubble is inserted even when IF/ID is held.
    if (bus.IF_ID_Flush) begin
      instr_next   = 32'h0;
      pcplus4_next = 32'h0;
      valid_next   = 1'b0;
    end else if (!bus.IF_ID_Stall) begin
      instr_next   = bus.IMem_Instr;
      pcplus4_next = pc_plus4;
      valid_next   = 1'b1;
    end

    // Hazard-unit outputs are expected to stall PC and IF/ID together, and
    // never to flush a stage whose PC is frozen. The flag is sticky.
    if ((bus.PC_Stall != bus.IF_ID_Stall) || (bus.IF_ID_Flush && bus.PC_Stall))
      err_next = 1'b1;

    if (bus.IF_ID_Stall && !bus.IF_ID_Flush && !(&stall_cnt_reg))
      stall_cnt_next = stall_cnt_reg + CNT_W'(1);
    if (bus.IF_ID_Flush && !(&flush_cnt_reg))
      flush_cnt_next = flush_cnt_reg + CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc_reg        <= RESET_PC;
      instr_reg     <= 32'h0;
      pcplus4_reg   <= 32'h0;
      valid_reg     <= 1'b0;
      err_reg       <= 1'b0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      pc_reg        <= pc_next;
      instr_reg     <= instr_next;
      pcplus4_reg   <= pcplus4_next;
      valid_reg     <= valid_next;
      err_reg       <= err_next;
      stall_cnt_reg <= stall_cnt_next;
      flush_cnt_reg <= flush_cnt_next;
    end
  end

  assign bus.IMem_Addr     = pc_reg;
  assign bus.IF_ID_Instr   = instr_reg;
  assign bus.IF_ID_PCPlus4 = pcplus4_reg;
  assign bus.IF_ID_Valid   = valid_reg;
  assign bus.Protocol_Err  = err_reg;
  assign bus.Stall_Count   = stall_cnt_reg;
  assign bus.Flush_Count   = flush_cnt_reg;

endmodule
